// File: rtl/seg7_rx_decoder.sv
// seg7_rx_decoder: debounces a seven-segment bus, decodes hex glyphs and times pattern changes
// Optional build macro SEG7_RX_BLANK_FILTER_EN: never accept the all-zero blank frame.
module seg7_rx_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int PERIOD_BIT    = 25
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [6:0]            seg_in,
   output logic [6:0]            seg_out,
   output logic [3:0]            digit_out,
   output logic                  digit_known,
   output logic                  change_pulse,
   output logic [PERIOD_BIT-1:0] period_out,
   output logic                  period_valid
);
   typedef enum logic [1:0] {IDLE, FIRST, RUN} state_t;
   localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);
   localparam logic [PERIOD_BIT-1:0] P_MAX = '1;
   state_t state, state_nxt;
   logic [6:0] s1, s2, s3;
   logic [3:0] cnt;
   logic [PERIOD_BIT-1:0] pcnt, p_next;
   logic [3:0] dec_digit;
   logic dec_known, blank_ok, accept;
`ifdef SEG7_RX_BLANK_FILTER_EN
   assign blank_ok = |s2;
`else
   assign blank_ok = 1'b1;
`endif
   // s2 must also match its previous sample so a stale saturated count cannot accept a fresh value
   assign accept = (cnt == CNT_MAX) && (s2 == s3) && blank_ok && (state == IDLE || s2 != seg_out);
   assign p_next = (pcnt == P_MAX) ? pcnt : pcnt + PERIOD_BIT'(1);
   // two-stage synchronizer, previous-sample copy and saturating stability count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1  <= '0;
         s2  <= '0;
         s3  <= '0;
         cnt <= '0;
      end else begin
         s1  <= seg_in;
         s2  <= s1;
         s3  <= s2;
         cnt <= (s2 != s3) ? 4'd0 : (cnt == CNT_MAX ? cnt : cnt + 4'd1);
      end
   end
   // glyph lookup on the synchronized sample
   always_comb begin
      dec_digit = 4'h0;
      dec_known = 1'b1;
      case (s2)
         7'h3F: dec_digit = 4'h0;
         7'h06: dec_digit = 4'h1;
         7'h5B: dec_digit = 4'h2;
         7'h4F: dec_digit = 4'h3;
         7'h66: dec_digit = 4'h4;
         7'h6D: dec_digit = 4'h5;
         7'h7D: dec_digit = 4'h6;
         7'h07: dec_digit = 4'h7;
         7'h7F: dec_digit = 4'h8;
         7'h6F: dec_digit = 4'h9;
         7'h77: dec_digit = 4'hA;
         7'h7C: dec_digit = 4'hB;
         7'h39: dec_digit = 4'hC;
         7'h5E: dec_digit = 4'hD;
         7'h79: dec_digit = 4'hE;
         7'h71: dec_digit = 4'hF;
         default: dec_known = 1'b0;
      endcase
   end
   // measurement state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else state <= state_nxt;
   end
   // IDLE -> FIRST -> RUN, advancing only on accepts
   always_comb begin
      state_nxt = state;
      state_nxt = !accept ? state : (state == IDLE ? FIRST : RUN);
   end
   // latch the accepted pattern and its decode, pulse once per accept
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_out      <= '0;
         digit_out    <= '0;
         digit_known  <= 1'b0;
         change_pulse <= 1'b0;
      end else begin
         change_pulse <= accept;
         if (accept) begin
            seg_out     <= s2;
            digit_out   <= dec_digit;
            digit_known <= dec_known;
         end
      end
   end
   // free-running saturating period counter, published on every accept after the first
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcnt         <= '0;
         period_out   <= '0;
         period_valid <= 1'b0;
      end else begin
         pcnt <= accept ? '0 : p_next;
         if (accept && state != IDLE) begin
            period_out   <= p_next;
            period_valid <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_seg7_rx_decoder.sv
// tb_seg7_rx_decoder: scoreboard bench for seg7_rx_decoder, default and 8-bit period builds
module tb_seg7_rx_decoder;
   localparam int PMAX = 33554431;
`ifdef SEG7_RX_BLANK_FILTER_EN
   localparam bit BLANK_FILT = 1'b1;
`else
   localparam bit BLANK_FILT = 1'b0;
`endif
   typedef struct {
      logic [6:0]  seg;
      logic [3:0]  dig;
      logic        kn;
      logic [24:0] per;
      logic        val;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [6:0] seg_in = 7'h3F;
   logic [6:0] seg_in8 = 7'h3F;
   logic [6:0] seg_out, seg_out8;
   logic [3:0] digit_out, digit_out8;
   logic digit_known, change_pulse, period_valid;
   logic digit_known8, change_pulse8, period_valid8;
   logic [24:0] period_out;
   logic [7:0] period_out8;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   exp_t q[$];
   exp_t mon_e;
   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   int m_acc = 0;
   int m_last = 0;
   logic [6:0] m_seg = '0;
   logic [24:0] m_per = '0;
   logic m_val = 1'b0;

   seg7_rx_decoder dut (
      .clk(clk), .reset(reset), .seg_in(seg_in), .seg_out(seg_out),
      .digit_out(digit_out), .digit_known(digit_known), .change_pulse(change_pulse),
      .period_out(period_out), .period_valid(period_valid)
   );

   seg7_rx_decoder #(.STABLE_CYCLES(4), .PERIOD_BIT(8)) dut8 (
      .clk(clk), .reset(reset), .seg_in(seg_in8), .seg_out(seg_out8),
      .digit_out(digit_out8), .digit_known(digit_known8), .change_pulse(change_pulse8),
      .period_out(period_out8), .period_valid(period_valid8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1);
   end

   // every pulse of the main instance pops one expectation
   always @(negedge clk) begin
      if (change_pulse) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL spurious_pulse: seg_out=%h with no accept expected", seg_out);
         end else begin
            mon_e = q.pop_front();
            if ({seg_out, digit_out, digit_known, period_out, period_valid} !==
                {mon_e.seg, mon_e.dig, mon_e.kn, mon_e.per, mon_e.val}) begin
               n_bad++;
               $display("FAIL accept: got seg=%h dig=%h kn=%b per=%0d val=%b, want seg=%h dig=%h kn=%b per=%0d val=%b",
                        seg_out, digit_out, digit_known, period_out, period_valid,
                        mon_e.seg, mon_e.dig, mon_e.kn, mon_e.per, mon_e.val);
            end
         end
      end
   end

   task automatic model_reset();
      m_acc = 0;
      m_seg = '0;
      m_per = '0;
      m_val = 1'b0;
   endtask

   task automatic model_accept(input logic [6:0] v);
      exp_t e;
      int d;
      if (BLANK_FILT && v == 7'h00) return;
      if (m_acc > 0 && v == m_seg) return;
      e.dig = 4'h0;
      e.kn = 1'b0;
      for (int i = 0; i < 16; i++)
         if (glyph[i] == v) begin
            e.dig = 4'(i);
            e.kn = 1'b1;
         end
      if (m_acc > 0) begin
         d = cyc - m_last;
         m_per = (d > PMAX) ? 25'(PMAX) : 25'(d);
         m_val = 1'b1;
      end
      m_acc++;
      m_last = cyc;
      m_seg = v;
      e.seg = v;
      e.per = m_per;
      e.val = m_val;
      q.push_back(e);
   endtask

   task automatic drive(input logic [6:0] v, input int hold);
      @(negedge clk);
      seg_in = v;
      if (hold >= 8) model_accept(v);
      repeat (hold - 1) @(negedge clk);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL %s_drain: %0d accepts still pending, want 0", name, q.size());
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_accept(seg_in);
      repeat (11) @(negedge clk);
      drive(7'h06, 12);
      drive(7'h5B, 12);
      drain("prereset");
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      n_cmp++;
      if (seg_out !== 7'h00) begin n_bad++; $display("FAIL reset_seg_out: got %h want 00", seg_out); end
      n_cmp++;
      if (digit_out !== 4'h0) begin n_bad++; $display("FAIL reset_digit_out: got %h want 0", digit_out); end
      n_cmp++;
      if (digit_known !== 1'b0) begin n_bad++; $display("FAIL reset_digit_known: got %b want 0", digit_known); end
      n_cmp++;
      if (change_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_change_pulse: got %b want 0", change_pulse); end
      n_cmp++;
      if (period_out !== 25'd0) begin n_bad++; $display("FAIL reset_period_out: got %0d want 0", period_out); end
      n_cmp++;
      if (period_valid !== 1'b0) begin n_bad++; $display("FAIL reset_period_valid: got %b want 0", period_valid); end
   endtask

   task automatic test_first();
      seg_in = 7'h3F;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_accept(7'h3F);
      for (int k = 0; k <= 6; k++) begin
         @(posedge clk);
         #1;
         if (k == 5) begin
            n_cmp++;
            if (change_pulse !== 1'b0) begin n_bad++; $display("FAIL latency_early: pulse=%b after edge 5, want 0", change_pulse); end
         end
         if (k == 6) begin
            n_cmp++;
            if (change_pulse !== 1'b1) begin n_bad++; $display("FAIL latency_edge6: pulse=%b after edge 6, want 1", change_pulse); end
         end
      end
      repeat (6) @(negedge clk);
      drain("first");
   endtask

   task automatic test_period();
      drive(7'h06, 100);
      drive(7'h5B, 12);
      drain("period");
   endtask

   task automatic test_glitch();
      drive(7'h66, 12);
      drive(7'h4F, 2);
      drive(7'h66, 12);
      drive(7'h4F, 1);
      drive(7'h66, 12);
      drain("glitch");
   endtask

   task automatic test_unknown();
      drive(7'h49, 10);
      drive(7'h71, 12);
      drain("unknown");
   endtask

   task automatic test_saturation();
      @(negedge clk);
      seg_in8 = 7'h06;
      repeat (300) @(negedge clk);
      seg_in8 = 7'h5B;
      repeat (20) @(negedge clk);
      n_cmp++;
      if (period_out8 !== 8'd255) begin n_bad++; $display("FAIL sat_period: got %0d want 255", period_out8); end
      n_cmp++;
      if (period_valid8 !== 1'b1) begin n_bad++; $display("FAIL sat_valid: got %b want 1", period_valid8); end
      repeat (30) @(negedge clk);
      seg_in8 = 7'h6D;
      repeat (20) @(negedge clk);
      n_cmp++;
      if (period_out8 !== 8'd50) begin n_bad++; $display("FAIL sat_after_period: got %0d want 50", period_out8); end
      n_cmp++;
      if (digit_out8 !== 4'h5) begin n_bad++; $display("FAIL sat_digit: got %h want 5", digit_out8); end
   endtask

   task automatic test_blank();
      drive(7'h3F, 12);
      drive(7'h00, 12);
      drive(7'h3F, 12);
      drive(7'h00, 12);
      drive(7'h3F, 12);
      repeat (20) @(negedge clk);
      drain("blank");
   endtask

   initial begin
      test_reset();
      test_first();
      test_period();
      test_glitch();
      test_unknown();
      test_saturation();
      test_blank();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/seg7_rx_decoder.md
Name: seg7_rx_decoder

Overview:
- Receive-side counterpart of the seven-segment animation driver.
- Samples a 7-bit segment bus, requires each pattern to be stable before accepting it, and decodes accepted patterns back to a hex digit.
- Measures the clock-cycle period between accepted pattern changes, so the bench or a companion board can recover both the displayed sequence and the speed setting.
- Sits on the uo_out[6:0] wires of the driver: loopback in simulation, or an external pin bus on a monitor design.

Parameters:
STABLE_CYCLES, 4, consecutive identical synchronized samples required before a pattern is accepted (legal range 1..15)
PERIOD_BIT, 25, width of period counter and period_out

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
seg_in  input  7  segment bus, active-high; bit0=a, bit1=b, ..., bit6=g
seg_out  output  7  last accepted pattern
digit_out  output  4  decoded hex value of seg_out; 0 when pattern unknown
digit_known  output  1  1 when seg_out matches one of the 16 hex glyphs
change_pulse  output  1  one-cycle pulse when a new pattern is accepted
period_out  output  PERIOD_BIT  clk cycles between the last two accepted changes
period_valid  output  1  period_out holds a real measurement

Behaviour:
- Reset: clock is clk. reset is asynchronous and active-high. Reset clears all registers. Reset values: seg_out=0, digit_out=0, digit_known=0, change_pulse=0, period_out=0, period_valid=0, FSM=IDLE.
- Synchronizer: seg_in passes through 2 flop stages (s1, s2).
- Stability counter (4 bits):
  - Set to 0 when s2 differs from its previous value.
  - Otherwise increments, saturating at STABLE_CYCLES-1.
- Accept condition: counter == STABLE_CYCLES-1, and (FSM==IDLE or s2 != seg_out).
- On accept, all registered at the same edge:
  - seg_out<=s2
  - digit_out and digit_known updated
  - change_pulse<=1 for exactly one cycle
- Latency: a new value first sampled at edge 0 produces change_pulse high after edge STABLE_CYCLES+2. With STABLE_CYCLES=4, that is after edge 6.
- Patterns that change before reaching stability are never accepted. They produce no pulse and no period restart.
- Decode table (hex seg -> digit):
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7
  - 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F
  - Any other pattern: digit_out=0, digit_known=0. The pattern is still accepted.
- Period counter (PERIOD_BIT wide):
  - Increments every cycle, saturating at all-ones.
  - On accept, its current value+1 (saturated) is copied to period_out, and the counter is cleared to 0.
  - period_out equals the edge distance between two accept edges.
- FSM:
  - IDLE: no pattern accepted yet. First accept -> FIRST; counter cleared, period_out unchanged, period_valid stays 0.
  - FIRST: next accept -> RUN; period_out loaded, period_valid<=1.
  - RUN: each accept reloads period_out. period_valid stays 1.
- Saturation: if the counter saturates before the next accept, period_out is loaded with 2^PERIOD_BIT-1 and period_valid is still set.
- Reset mid-measurement returns to IDLE immediately. The next two accepts are needed for period_valid.
- Same pattern held indefinitely: no further pulses. The counter saturates silently.

Optional Feature:
SEG7_RX_BLANK_FILTER_EN
- Defined: the all-zero pattern (blank frame between animation steps) is never accepted. No change_pulse, and the period counter keeps running. A blank→X→blank→X sequence yields only the first X accept; later X frames equal seg_out and are ignored.
- Undefined: the blank is treated as an ordinary unknown pattern. It is accepted with digit_known=0 and restarts the period.

Test Plan:
1. Reset asserted mid-run → all outputs 0 at once, asynchronously. Release, drive seg_in=0x3F steady → change_pulse after edge 6, seg_out=0x3F, digit_out=0, digit_known=1, period_valid=0.
2. Drive 0x06, hold 100 cycles, then 0x5B → second pulse: digit_out=1. Third pulse: digit_out=2, period_out=100, period_valid=1.
3. Glitch: 0x4F for 2 cycles amid steady 0x66 → no pulse on 0x4F. One pulse for 0x66, digit_out=4.
4. Unknown 0x49 held 10 cycles → pulse, digit_known=0, digit_out=0, seg_out=0x49. Then 0x71 → digit_out=F, digit_known=1.
5. PERIOD_BIT=8: two accepts 300 cycles apart → period_out=255, period_valid=1.
6. Blank 0x00 inserted between 0x3F frames. With SEG7_RX_BLANK_FILTER_EN: one pulse total. Without it: pulses for 0x3F, 0x00 (digit_known=0), 0x3F.
